// File: rtl/instruction_fetch.sv
// IF stage: PC register, loader-written instruction memory and the IF/ID register.
// Handles redirects from ID, hazard stalls, debug enable, and a sticky HALT freeze.
module instruction_fetch #(
    parameter int unsigned          NB_DATA    = 32,
    parameter int unsigned          MEM_DEPTH  = 256,
    parameter int unsigned          NB_MADDR   = $clog2(MEM_DEPTH),
    parameter logic [NB_DATA-1:0]   HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_stall,
    input  logic                i_jump,
    input  logic [NB_DATA-1:0]  i_addr2jump,
    input  logic                i_wr_en,
    input  logic [NB_MADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0]  i_wr_data,
    output logic [NB_DATA-1:0]  o_instruction,
    output logic [NB_DATA-1:0]  o_pcounter4,
    output logic                o_valid,
    output logic [NB_DATA-1:0]  o_pc,
    output logic                o_halt
);

    logic [NB_DATA-1:0] mem [MEM_DEPTH];
    logic [NB_DATA-1:0] fetch_word_c;
    logic [NB_DATA-1:0] pc_plus4_c;
    logic [NB_DATA-1:0] jump_target_c;
    logic               fetch_is_halt_c;

    // Combinational read; a same-edge loader write is seen only by the next fetch
    assign fetch_word_c    = mem[o_pc[NB_MADDR+1:2]];
    assign pc_plus4_c      = o_pc + NB_DATA'(4);
    assign jump_target_c   = i_addr2jump & ~NB_DATA'(3);
    assign fetch_is_halt_c = (fetch_word_c == HALT_INSTR);

    // Loader port is independent of enable, stall and halt; contents survive reset
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    // PC and IF/ID register; a disabled or stalled stage ignores redirects entirely
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_pc          <= '0;
            o_instruction <= '0;
            o_pcounter4   <= '0;
            o_valid       <= 1'b0;
            o_halt        <= 1'b0;
        end else if (i_en && !i_stall) begin
            if (o_halt || i_jump) begin
                o_instruction <= '0;
                o_pcounter4   <= '0;
                o_valid       <= 1'b0;
                if (!o_halt) begin
                    o_pc <= jump_target_c;
                end
            end else begin
                o_instruction <= fetch_word_c;
                o_pcounter4   <= pc_plus4_c;
                o_valid       <= 1'b1;
                if (fetch_is_halt_c) begin
                    o_halt <= 1'b1;
                end else begin
                    o_pc <= pc_plus4_c;
                end
            end
        end
    end

endmodule
